id_ex_stage: RTL and testbench

//  ID->EX pipeline stage downstream of the register file. Registers the decoded

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with write-through bypass, stall hold and flush bubbles
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [4:0]        inReg1,
    input  logic [4:0]        inReg2,
    input  logic [CTRL_W-1:0] inCtrl,
    input  logic [DATA_W-1:0] inImm,
    input  logic              stall,
    input  logic              flush,
    input  logic              wbRegWr,
    input  logic [4:0]        wbWrReg,
    input  logic [DATA_W-1:0] wbWrData,
    input  logic [DATA_W-1:0] rfData1,
    input  logic [DATA_W-1:0] rfData2,
    output logic              exValid,
    output logic [CTRL_W-1:0] exCtrl,
    output logic [DATA_W-1:0] exImm,
    output logic [4:0]        exReg1,
    output logic [4:0]        exReg2,
    output logic [DATA_W-1:0] exOpA,
    output logic [DATA_W-1:0] exOpB
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t            state;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] hold1;
    logic [DATA_W-1:0] hold2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Writeback hitting the register being captured: regfile returns the stale value.
    logic cap_hit1;
    logic cap_hit2;
    // Writeback hitting a register whose operand is parked in the hold regs.
    logic held_hit1;
    logic held_hit2;

    assign cap_hit1  = wbRegWr && (wbWrReg == inReg1) && (inReg1 != 5'd0);
    assign cap_hit2  = wbRegWr && (wbWrReg == inReg2) && (inReg2 != 5'd0);
    assign held_hit1 = wbRegWr && (wbWrReg == exReg1) && (exReg1 != 5'd0);
    assign held_hit2 = wbRegWr && (wbWrReg == exReg2) && (exReg2 != 5'd0);

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            FRESH: begin
                if (exReg1 != 5'd0) op_a = byp1 ? byp_data : rfData1;
                if (exReg2 != 5'd0) op_b = byp2 ? byp_data : rfData2;
            end
            HELD: begin
                op_a = hold1;
                op_b = hold2;
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    assign exOpA = op_a;
    assign exOpB = op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            exValid  <= 1'b0;
            exCtrl   <= '0;
            exImm    <= '0;
            exReg1   <= 5'd0;
            exReg2   <= 5'd0;
            byp1     <= 1'b0;
            byp2     <= 1'b0;
            byp_data <= '0;
            hold1    <= '0;
            hold2    <= '0;
        end else begin
            // Hold regs snapshot the live operand on entry to HELD and then track
            // later writebacks so the newest older write is what EX finally sees.
            if (state == FRESH && stall && !flush) begin
                hold1 <= held_hit1 ? wbWrData : op_a;
                hold2 <= held_hit2 ? wbWrData : op_b;
            end else if (state == HELD) begin
                if (held_hit1) hold1 <= wbWrData;
                if (held_hit2) hold2 <= wbWrData;
            end

            if (flush) begin
                state   <= EMPTY;
                exValid <= 1'b0;
                exCtrl  <= '0;
            end else if (stall) begin
                if (state == FRESH) state <= HELD;
            end else if (inValid) begin
                state    <= FRESH;
                exValid  <= 1'b1;
                exCtrl   <= inCtrl;
                exImm    <= inImm;
                exReg1   <= inReg1;
                exReg2   <= inReg2;
                byp1     <= cap_hit1;
                byp2     <= cap_hit2;
                byp_data <= wbWrData;
            end else begin
                state   <= EMPTY;
                exValid <= 1'b0;
                exCtrl  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with a pre-write-read register file model
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_reg1;
    logic [4:0]  in_reg2;
    logic [15:0] in_ctrl;
    logic [31:0] in_imm;
    logic        stall;
    logic        flush;
    logic        wb_reg_wr;
    logic [4:0]  wb_wr_reg;
    logic [31:0] wb_wr_data;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        ex_valid;
    logic [15:0] ex_ctrl;
    logic [31:0] ex_imm;
    logic [4:0]  ex_reg1;
    logic [4:0]  ex_reg2;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;

    logic [31:0] regs [32];

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb[$];

    int n_vec;
    int n_bad;

    id_ex_stage #(.DATA_W(32), .CTRL_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (in_valid),
        .inReg1   (in_reg1),
        .inReg2   (in_reg2),
        .inCtrl   (in_ctrl),
        .inImm    (in_imm),
        .stall    (stall),
        .flush    (flush),
        .wbRegWr  (wb_reg_wr),
        .wbWrReg  (wb_wr_reg),
        .wbWrData (wb_wr_data),
        .rfData1  (rf_data1),
        .rfData2  (rf_data2),
        .exValid  (ex_valid),
        .exCtrl   (ex_ctrl),
        .exImm    (ex_imm),
        .exReg1   (ex_reg1),
        .exReg2   (ex_reg2),
        .exOpA    (ex_op_a),
        .exOpB    (ex_op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous read returning the pre-write value; r0 is stored like any register.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            rf_data1 <= 32'd0;
            rf_data2 <= 32'd0;
        end else begin
            rf_data1 <= regs[in_reg1];
            rf_data2 <= regs[in_reg2];
            if (wb_reg_wr) regs[wb_wr_reg] <= wb_wr_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [15:0] ctrl, input logic [31:0] imm,
                       input logic st, input logic fl,
                       input logic wr, input logic [4:0] wreg, input logic [31:0] wd,
                       input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [31:0] eimm, input logic [15:0] ectrl);
        exp_t e;
        @(negedge clk);
        in_valid   = v;
        in_reg1    = r1;
        in_reg2    = r2;
        in_ctrl    = ctrl;
        in_imm     = imm;
        stall      = st;
        flush      = fl;
        wb_reg_wr  = wr;
        wb_wr_reg  = wreg;
        wb_wr_data = wd;
        e.v = ev; e.a = ea; e.b = eb; e.imm = eimm; e.ctrl = ectrl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("valid", {63'd0, ex_valid}, {63'd0, e.v});
        check("op_a", {32'd0, ex_op_a}, {32'd0, e.a});
        check("op_b", {32'd0, ex_op_b}, {32'd0, e.b});
        check("ctrl", {48'd0, ex_ctrl}, {48'd0, e.ctrl});
        if (e.v) check("imm", {32'd0, ex_imm}, {32'd0, e.imm});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 0; in_reg1 = 0; in_reg2 = 0; in_ctrl = 0; in_imm = 0;
        stall = 0; flush = 0; wb_reg_wr = 0; wb_wr_reg = 0; wb_wr_data = 0;
        @(posedge clk);
        #1;
        check("rst_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_op_a", {32'd0, ex_op_a}, 64'd0);
        check("rst_op_b", {32'd0, ex_op_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // preload r5, r6
        cyc(0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 5, 32'h11, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        cyc(0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 6, 32'h33, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        // plain pass
        cyc(1, 5, 6, 16'h1234, 32'h7, 0, 0, 0, 0, 32'h0, 1, 32'h11, 32'h33, 32'h7, 16'h1234);
        // same-edge hazard on both operands
        cyc(1, 5, 5, 16'h0002, 32'h9, 0, 0, 1, 5, 32'hAB, 1, 32'hAB, 32'hAB, 32'h9, 16'h0002);
        cyc(1, 5, 6, 16'h0003, 32'h1, 0, 0, 0, 0, 32'h0, 1, 32'hAB, 32'h33, 32'h1, 16'h0003);
        // r0 written, then read with a same-edge r0 write
        cyc(0, 0, 0, 16'h0, 32'h0, 0, 0, 1, 0, 32'hFF, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        cyc(1, 0, 5, 16'h0004, 32'h2, 0, 0, 1, 0, 32'hEE, 1, 32'h0, 32'hAB, 32'h2, 16'h0004);
        // stall sequence with writebacks to held registers
        cyc(1, 5, 6, 16'h00C0, 32'h55, 0, 0, 1, 5, 32'h11, 1, 32'h11, 32'h33, 32'h55, 16'h00C0);
        cyc(1, 7, 5, 16'hDEAD, 32'h66, 1, 0, 0, 0, 32'h0, 1, 32'h11, 32'h33, 32'h55, 16'h00C0);
        cyc(1, 7, 5, 16'hDEAD, 32'h66, 1, 0, 1, 5, 32'h22, 1, 32'h22, 32'h33, 32'h55, 16'h00C0);
        cyc(1, 7, 5, 16'hDEAD, 32'h66, 1, 0, 1, 6, 32'h44, 1, 32'h22, 32'h44, 32'h55, 16'h00C0);
        cyc(1, 7, 5, 16'hDEAD, 32'h66, 0, 0, 1, 7, 32'h77, 1, 32'h77, 32'h22, 32'h66, 16'hDEAD);
        // flush beats stall; stall in EMPTY stays empty
        cyc(1, 5, 6, 16'h0BAD, 32'h3, 1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        cyc(1, 5, 6, 16'h0BAD, 32'h3, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        // write on the FRESH->HELD edge lands in the hold reg; r0 never held nonzero
        cyc(1, 6, 0, 16'h0005, 32'h8, 0, 0, 0, 0, 32'h0, 1, 32'h44, 32'h0, 32'h8, 16'h0005);
        cyc(1, 6, 0, 16'h0005, 32'h8, 1, 0, 1, 6, 32'h99, 1, 32'h99, 32'h0, 32'h8, 16'h0005);
        cyc(1, 6, 0, 16'h0005, 32'h8, 1, 0, 1, 0, 32'h5, 1, 32'h99, 32'h0, 32'h8, 16'h0005);
        // flush alone, then capture, then a bubble
        cyc(1, 6, 0, 16'h0005, 32'h8, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        cyc(1, 5, 6, 16'h0006, 32'hA, 0, 0, 0, 0, 32'h0, 1, 32'h22, 32'h99, 32'hA, 16'h0006);
        cyc(0, 5, 6, 16'h0007, 32'hB, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 16'h0);
        // async reset mid-stall
        cyc(1, 5, 6, 16'h0008, 32'hC, 0, 0, 0, 0, 32'h0, 1, 32'h22, 32'h99, 32'hC, 16'h0008);
        cyc(1, 5, 6, 16'h0008, 32'hC, 1, 0, 0, 0, 32'h0, 1, 32'h22, 32'h99, 32'hC, 16'h0008);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, ex_valid}, 64'd0);
        check("arst_op_a", {32'd0, ex_op_a}, 64'd0);
        check("arst_op_b", {32'd0, ex_op_b}, 64'd0);
        check("arst_ctrl", {48'd0, ex_ctrl}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 16'h0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 16'h0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
